// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 median datapath: default image geometry, pixel width
// and the row-major S1..S9 window index convention used by producer and calc stages.
package window_3x3_gen_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_COL_W  = 10;
    localparam int DEF_ROW_W  = 9;
    localparam int WIN_DIM    = 3;
    localparam int WIN_SIZE   = WIN_DIM * WIN_DIM;

    // S1..S3 top row, S4..S6 middle row, S7..S9 bottom row; S5 is the centre pixel.
    typedef enum logic [3:0] {
        WIN_S1 = 4'd0,
        WIN_S2 = 4'd1,
        WIN_S3 = 4'd2,
        WIN_S4 = 4'd3,
        WIN_S5 = 4'd4,
        WIN_S6 = 4'd5,
        WIN_S7 = 4'd6,
        WIN_S8 = 4'd7,
        WIN_S9 = 4'd8
    } win_pos_e;

    function automatic int winIdx(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream input and 3x3 window output bundle between the raster source,
// the window generator and the median calc stage.
interface window_3x3_gen_if
    import window_3x3_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] S1, S2, S3, S4, S5, S6, S7, S8, S9;
    logic              done_o;
    logic              frame_end_o;

    modport master (
        output valid_i, data_i,
        input  S1, S2, S3, S4, S5, S6, S7, S8, S9, done_o, frame_end_o
    );

    modport slave (
        input  valid_i, data_i,
        output S1, S2, S3, S4, S5, S6, S7, S8, S9, done_o, frame_end_o
    );
endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of pixel storage: synchronous write, combinational read, so a read
// and write to the same column in one cycle returns the old contents.
module window_3x3_gen_line_buffer
    import window_3x3_gen_pkg::*;
#(
    parameter int DEPTH  = DEF_IMG_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_COL_W
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // No reset: rows 0-1 of every frame emit nothing, so stale contents never reach the output.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-to-3x3-window generator: two line buffers feed a 3x3 shift window, and only
// fully interior windows are registered out with a one-cycle done_o strobe.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COL_W  = DEF_COL_W,
    parameter int ROW_W  = DEF_ROW_W
) (
    input  logic           clk,
    input  logic           rst,
    window_3x3_gen_if.slave bus
);
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] win_q [WIN_SIZE];
    logic [DATA_W-1:0] win_d [WIN_SIZE];
    logic [DATA_W-1:0] out_q [WIN_SIZE];
    logic              done_q;
    logic              frameEnd_q;
    logic [DATA_W-1:0] lb0Rdata;
    logic [DATA_W-1:0] lb1Rdata;
    logic              accept;
    logic              colWrap;
    logic              rowWrap;
    logic              emit;

    assign accept  = bus.valid_i;
    assign colWrap = (col_q == COL_W'(IMG_W - 1));
    assign rowWrap = (row_q == ROW_W'(IMG_H - 1));
    assign emit    = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    // lb0 holds row r-1, lb1 row r-2; lb1 is refilled with what lb0 held before this write.
    window_3x3_gen_line_buffer #(
        .DEPTH (IMG_W),
        .DATA_W(DATA_W),
        .ADDR_W(COL_W)
    ) lb0 (
        .clk    (clk),
        .wr_en_i(accept),
        .addr_i (col_q),
        .wdata_i(bus.data_i),
        .rdata_o(lb0Rdata)
    );

    window_3x3_gen_line_buffer #(
        .DEPTH (IMG_W),
        .DATA_W(DATA_W),
        .ADDR_W(COL_W)
    ) lb1 (
        .clk    (clk),
        .wr_en_i(accept),
        .addr_i (col_q),
        .wdata_i(lb0Rdata),
        .rdata_o(lb1Rdata)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (colWrap) begin
                col_d = '0;
                row_d = rowWrap ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < WIN_SIZE; k++) begin
            win_d[k] = win_q[k];
        end
        if (accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                win_d[winIdx(r, 0)] = win_q[winIdx(r, 1)];
                win_d[winIdx(r, 1)] = win_q[winIdx(r, 2)];
            end
            win_d[winIdx(0, 2)] = lb1Rdata;
            win_d[winIdx(1, 2)] = lb0Rdata;
            win_d[winIdx(2, 2)] = bus.data_i;
        end
    end

    // The window shifts on every accepted pixel; the output registers only capture interior windows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            done_q     <= 1'b0;
            frameEnd_q <= 1'b0;
            for (int k = 0; k < WIN_SIZE; k++) begin
                win_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            done_q     <= emit;
            frameEnd_q <= emit && colWrap && rowWrap;
            for (int k = 0; k < WIN_SIZE; k++) begin
                win_q[k] <= win_d[k];
                if (emit) begin
                    out_q[k] <= win_d[k];
                end
            end
        end
    end

    assign bus.S1          = out_q[WIN_S1];
    assign bus.S2          = out_q[WIN_S2];
    assign bus.S3          = out_q[WIN_S3];
    assign bus.S4          = out_q[WIN_S4];
    assign bus.S5          = out_q[WIN_S5];
    assign bus.S6          = out_q[WIN_S6];
    assign bus.S7          = out_q[WIN_S7];
    assign bus.S8          = out_q[WIN_S8];
    assign bus.S9          = out_q[WIN_S9];
    assign bus.done_o      = done_q;
    assign bus.frame_end_o = frameEnd_q;

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Producer side of the 3x3 median datapath: turns a raster-order pixel stream into 3x3 neighbourhoods S1..S9 with a per-window strobe done_o.
- Its outputs connect directly to the 3x3 median calc stage inputs (S1..S9, done_i).
- Two internal line buffers plus a 3x3 shift window; emits only fully-interior windows (no border padding).

Parameters:
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)
- DATA_W, 8, pixel width
- COL_W, 10, column counter width (>= clog2(IMG_W))
- ROW_W, 9, row counter width (>= clog2(IMG_H))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  data_i carries the next raster pixel this cycle
- data_i  in  DATA_W  pixel
- S1..S9  out  DATA_W each  window, row-major: S1..S3 top row, S4..S6 middle, S7..S9 bottom; left to right
- done_o  out  1  S1..S9 hold a valid window this cycle (one-cycle strobe)
- frame_end_o  out  1  pulses together with the last window of a frame

Behaviour:
- Reset (rst=0, asynchronous): col/row counters=0, window registers=0, S1..S9=0, done_o=0, frame_end_o=0. Line-buffer RAM is not cleared; stale contents are never emitted.
- Counters advance only on valid_i=1. col increments and wraps IMG_W-1 -> 0; on wrap, row increments and wraps IMG_H-1 -> 0.
- Pixel at (r,c) accepted:
  - Read lb0[c] (row r-1) and lb1[c] (row r-2).
  - Write lb1[c] <= old lb0[c] and lb0[c] <= data_i. Read-before-write at the same address in the same cycle.
  - Shift window columns left; new right column = {lb1[c], lb0[c], data_i}.
- Output is registered with latency 1 cycle. If the accepted pixel has r>=2 and c>=2, the next cycle has done_o=1 with:
  - S1=P(r-2,c-2) S2=P(r-2,c-1) S3=P(r-2,c)
  - S4=P(r-1,c-2) S5=P(r-1,c-1) S6=P(r-1,c)
  - S7=P(r,c-2) S8=P(r,c-1) S9=P(r,c)
  - S5 is the centre pixel (r-1,c-1).
- Otherwise, including valid_i=0 cycles, done_o=0 and S1..S9 hold their last values.
- Windows per frame = (IMG_W-2)*(IMG_H-2).
- frame_end_o=1 exactly in the cycle done_o=1 for pixel (IMG_H-1, IMG_W-1).
- Gaps: valid_i may drop for any number of cycles. State is frozen, and the resulting window sequence is identical to the gapless case.
- Line boundary: columns 0 and 1 of each row produce no window. Window columns from the previous row are flushed by the c>=2 rule, never by clearing.
- Frame boundary: a new frame starts at row 0 immediately after the wrap. Rows 0-1 of the new frame emit nothing, so there is no mixing with the previous frame. Back-to-back frames need no idle cycles.
- Mid-frame reset: counters return to (0,0) and the next accepted pixel is treated as P(0,0).
- No backpressure: the downstream stage always accepts. Throughput is one window per clock.

Decomposition:
- Shared package: DATA_W default, the image-size defaults, and the window index convention (S1..S9 row-major) used by both producer and calc.
- One natural sub-module: line_buffer. It is a single-port-style dual-access RAM (depth IMG_W, width DATA_W) with synchronous write and combinational/same-cycle read-before-write. It is instantiated twice (lb0, lb1), or as one 2*DATA_W-wide instance.
- Counters, window shift registers and output registers live in the top.

Test Plan:
- IMG_W=4, IMG_H=4, pixel value = 4r+c+1 (1..16), valid_i continuous:
  - First done_o occurs 1 cycle after pixel 11.
  - S1..S9 = 1,2,3,5,6,7,9,10,11.
  - 4 windows total.
- Same frame, last window: S1..S9 = 6,7,8,10,11,12,14,15,16, with frame_end_o=1 in the same cycle. frame_end_o is 0 on the other 3 windows.
- Same frame with valid_i toggled 1,0,0,1,... (random gaps): same 4 windows in the same order. done_o is never asserted while no pixel was accepted the previous cycle.
- Two back-to-back frames, second frame values +100:
  - Second frame's first window = 101,102,103,105,106,107,109,110,111.
  - No window mixes values from the two frames.
  - 8 windows total.
- Reset asserted (rst=0) after pixel 9 of frame 1, then released and a fresh frame sent:
  - done_o=0 and S1..S9=0 immediately on assertion.
  - The fresh frame produces exactly the 4 windows of test 1.
- IMG_W=5, IMG_H=3, values 1..15:
  - Exactly 3 windows, centres 7, 8, 9.
  - Last window = 3,4,5,8,9,10,13,14,15, with frame_end_o=1.
